// File: rtl/lshifup_sync_bank.sv
// Clocked low-to-high level-shifter bank: per-channel multi-flop synchronizers
// plus an isolation/power-up sequencer that clamps Y until the source domain is
// powered, settled and its synchronizer pipeline has been flushed.
module lshifup_sync_bank #(
   parameter int unsigned      WIDTH         = 8,
   parameter int unsigned      SYNC_STAGES   = 2,
   parameter int unsigned      SETTLE_CYCLES = 16,
   parameter logic [WIDTH-1:0] CLAMP_VAL     = '0
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic             PWR_OK,
   input  logic             ISO_REQ,
   output logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] Y_CHG,
   output logic             READY,
   output logic [1:0]       STATE
);

   localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SYNC_STAGES) ? SETTLE_CYCLES : SYNC_STAGES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_ISO    = 2'b00,
      ST_SETTLE = 2'b01,
      ST_FLUSH  = 2'b10,
      ST_ACTIVE = 2'b11
   } state_t;

   state_t                               state;
   state_t                               state_nxt;
   logic [CNT_W-1:0]                     cnt;
   logic [CNT_W-1:0]                     cnt_nxt;
   logic [SYNC_STAGES-1:0]               pok_sync;
   logic                                 pok_s;
   logic                                 abort;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]    dsync;
   logic [WIDTH-1:0]                     y_nxt;

   assign pok_s = pok_sync[SYNC_STAGES-1];
   assign abort = ~pok_s | ISO_REQ;

   // Power-good synchronizer into the CLK domain
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         pok_sync <= '0;
      end else begin
         pok_sync <= {pok_sync[SYNC_STAGES-2:0], PWR_OK};
      end
   end

   // Data synchronizers; held at the clamp value while isolated so stale data never leaks
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         dsync <= {SYNC_STAGES{CLAMP_VAL}};
      end else if (state == ST_ISO) begin
         dsync <= {SYNC_STAGES{CLAMP_VAL}};
      end else begin
         dsync <= {dsync[SYNC_STAGES-2:0], A};
      end
   end

   // Sequencer next state: abort dominates, counter reloaded on every transition
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ST_ISO: begin
            if (!abort) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
            end
         end
         ST_SETTLE: begin
            if (abort) begin
               state_nxt = ST_ISO;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = ST_FLUSH;
               cnt_nxt   = CNT_W'(SYNC_STAGES - 1);
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         ST_FLUSH: begin
            if (abort) begin
               state_nxt = ST_ISO;
               cnt_nxt   = '0;
            end else if (cnt == '0) begin
               state_nxt = ST_ACTIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt - CNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            if (abort) begin
               state_nxt = ST_ISO;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = ST_ISO;
            cnt_nxt   = '0;
         end
      endcase
      y_nxt = (state_nxt == ST_ACTIVE) ? dsync[SYNC_STAGES-1] : CLAMP_VAL;
   end

   // State, counter and registered outputs; clamp lands on the same edge as the exit
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state <= ST_ISO;
         cnt   <= '0;
         Y     <= CLAMP_VAL;
         Y_CHG <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         Y     <= y_nxt;
         Y_CHG <= ((state == ST_ACTIVE) && (state_nxt == ST_ACTIVE)) ? (y_nxt ^ Y) : '0;
      end
   end

   assign READY = (state == ST_ACTIVE);
   assign STATE = state;

endmodule

// File: tb/tb_lshifup_sync_bank.sv
// Bench for lshifup_sync_bank: two configurations share one stimulus stream and
// are compared every cycle against an edge-history reference model.
module tb_lshifup_sync_bank;

   localparam int unsigned S0  = 2;
   localparam int unsigned SC0 = 4;
   localparam logic [7:0]  CL0 = 8'h00;
   localparam int unsigned S1  = 4;
   localparam int unsigned SC1 = 1;
   localparam logic [7:0]  CL1 = 8'hFF;
   localparam int          HL  = 64;

   logic       clk = 1'b0;
   logic       rn;
   logic       pwr;
   logic       iso;
   logic [7:0] a;
   logic [7:0] y0, yc0, y1, yc1;
   logic       rdy0, rdy1;
   logic [1:0] st0, st1;

   always #5 clk = ~clk;

   lshifup_sync_bank #(.WIDTH(8), .SYNC_STAGES(S0), .SETTLE_CYCLES(SC0), .CLAMP_VAL(CL0)) dut0 (
      .CLK(clk), .RN(rn), .A(a), .PWR_OK(pwr), .ISO_REQ(iso),
      .Y(y0), .Y_CHG(yc0), .READY(rdy0), .STATE(st0)
   );

   lshifup_sync_bank #(.WIDTH(8), .SYNC_STAGES(S1), .SETTLE_CYCLES(SC1), .CLAMP_VAL(CL1)) dut1 (
      .CLK(clk), .RN(rn), .A(a), .PWR_OK(pwr), .ISO_REQ(iso),
      .Y(y1), .Y_CHG(yc1), .READY(rdy1), .STATE(st1)
   );

   int         n_chk  = 0;
   int         n_pass = 0;

   // Reference model: run = edges spent out of isolation (0 = isolated)
   int         cyc [2];
   int         run [2];
   bit         ph  [2][HL];
   logic [7:0] ah  [2][HL];
   logic [7:0] ym  [2];
   logic [7:0] ycm [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
   endtask

   function automatic int exp_state(input int i, input int s, input int sc);
      if (run[i] == 0)            return 0;
      else if (run[i] <= sc)      return 1;
      else if (run[i] <= sc + s)  return 2;
      else                        return 3;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         cyc[i] = 0;
         run[i] = 0;
         ycm[i] = 8'h00;
      end
      ym[0] = CL0;
      ym[1] = CL1;
   endtask

   // One rising edge: the synchronized view of an input is its value s edges ago
   task automatic model_step(input int i, input int s, input int sc, input logic [7:0] cl);
      bit         pok;
      bit         was_act;
      bit         act;
      logic [7:0] a_old;
      logic [7:0] y_new;
      int         lim;
      lim   = sc + s;
      pok   = (cyc[i] >= s) ? ph[i][(cyc[i] - s) % HL] : 1'b0;
      a_old = (cyc[i] >= s) ? ah[i][(cyc[i] - s) % HL] : cl;
      ph[i][cyc[i] % HL] = pwr;
      ah[i][cyc[i] % HL] = a;
      cyc[i]++;
      was_act = (run[i] > lim);
      if (run[i] == 0) begin
         if (pok && !iso) run[i] = 1;
      end else if (!pok || iso) begin
         run[i] = 0;
      end else if (run[i] <= lim) begin
         run[i]++;
      end
      act    = (run[i] > lim);
      y_new  = act ? a_old : cl;
      ycm[i] = (was_act && act) ? (y_new ^ ym[i]) : 8'h00;
      ym[i]  = y_new;
   endtask

   task automatic compare_all();
      check("y0",     64'(y0),   64'(ym[0]));
      check("ychg0",  64'(yc0),  64'(ycm[0]));
      check("state0", 64'(st0),  64'(exp_state(0, S0, SC0)));
      check("ready0", 64'(rdy0), 64'(exp_state(0, S0, SC0) == 3));
      check("y1",     64'(y1),   64'(ym[1]));
      check("ychg1",  64'(yc1),  64'(ycm[1]));
      check("state1", 64'(st1),  64'(exp_state(1, S1, SC1)));
      check("ready1", 64'(rdy1), 64'(exp_state(1, S1, SC1) == 3));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, S0, SC0, CL0);
      model_step(1, S1, SC1, CL1);
      #1;
      compare_all();
   endtask

   // Asynchronous reset between edges; released 2 time units after the next edge
   task automatic do_reset();
      #2;
      rn = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_y0_clamp", 64'(y0), 64'(CL0));
      check("rst_y1_clamp", 64'(y1), 64'(CL1));
      @(posedge clk);
      #2;
      rn = 1'b1;
   endtask

   // Power-up timing with PWR_OK and A=A5 already applied before e0
   task automatic powerup_seq(input string tag);
      for (int e = 0; e <= 10; e++) begin
         tick();
         if (e == 1) check({tag, "_iso0"},    64'(st0), 64'(2'b00));
         if (e == 2) check({tag, "_settle0"}, 64'(st0), 64'(2'b01));
         if (e == 5) check({tag, "_settle0b"},64'(st0), 64'(2'b01));
         if (e == 6) check({tag, "_flush0"},  64'(st0), 64'(2'b10));
         if (e == 7) check({tag, "_flush0b"}, 64'(st0), 64'(2'b10));
         if (e == 8) begin
            check({tag, "_active0"}, 64'(st0),  64'(2'b11));
            check({tag, "_ready0"},  64'(rdy0), 64'(1));
            check({tag, "_y0"},      64'(y0),   64'(8'hA5));
            check({tag, "_flush1"},  64'(st1),  64'(2'b10));
         end
         if (e == 9) begin
            check({tag, "_active1"}, 64'(st1), 64'(2'b11));
            check({tag, "_y1"},      64'(y1),  64'(8'hA5));
         end
         check({tag, "_ychg0"}, 64'(yc0), 64'(0));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      int k;
      rn  = 1'b1;
      pwr = 1'b0;
      iso = 1'b0;
      a   = 8'h00;
      #1;
      rn = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("rst_state0", 64'(st0), 64'(0));
      check("rst_y1",     64'(y1),  64'(8'hFF));
      @(posedge clk);
      #2;
      rn = 1'b1;

      // Unpowered source: stays isolated
      repeat (3) tick();

      // Power-up
      pwr = 1'b1;
      a   = 8'hA5;
      powerup_seq("pu");

      // Data change in ACTIVE: latency SYNC_STAGES+1 edges, one-cycle change pulse
      a = 8'h5A;
      for (int e = 0; e <= 5; e++) begin
         tick();
         if (e == 1) check("chg_y0_old", 64'(y0),  64'(8'hA5));
         if (e == 2) begin
            check("chg_y0",    64'(y0),  64'(8'h5A));
            check("chg_ychg0", 64'(yc0), 64'(8'hFF));
         end
         if (e == 3) check("chg_ychg0_end", 64'(yc0), 64'(8'h00));
         if (e == 4) begin
            check("chg_y1",    64'(y1),  64'(8'h5A));
            check("chg_ychg1", 64'(yc1), 64'(8'hFF));
         end
         if (e == 5) check("chg_ychg1_end", 64'(yc1), 64'(8'h00));
      end

      // Power loss: clamp after SYNC_STAGES edges, no change pulse
      pwr = 1'b0;
      for (int e = 0; e <= 5; e++) begin
         tick();
         if (e == 1) check("loss_still0", 64'(st0), 64'(3));
         if (e == 2) begin
            check("loss_state0", 64'(st0),  64'(0));
            check("loss_y0",     64'(y0),   64'(8'h00));
            check("loss_ready0", 64'(rdy0), 64'(0));
         end
         if (e == 4) begin
            check("loss_state1", 64'(st1), 64'(0));
            check("loss_y1",     64'(y1),  64'(8'hFF));
         end
         check("loss_ychg0", 64'(yc0), 64'(0));
      end
      repeat (4) begin
         a = 8'($urandom);
         tick();
         check("iso_y0_clamped", 64'(y0), 64'(8'h00));
      end

      // ISO_REQ pulse in FLUSH, then the full sequence restarts
      pwr = 1'b1;
      k = 0;
      while (st0 != 2'b10 && k < 40) begin
         tick();
         k++;
      end
      check("reach_flush0", 64'(st0), 64'(2'b10));
      iso = 1'b1;
      tick();
      check("isoreq_abort0", 64'(st0), 64'(0));
      check("isoreq_y0",     64'(y0),  64'(8'h00));
      iso = 1'b0;
      for (int e = 0; e <= 6; e++) begin
         tick();
         if (e == 0) check("restart_settle0", 64'(st0), 64'(2'b01));
         if (e == 3) check("restart_settle0b",64'(st0), 64'(2'b01));
         if (e == 4) check("restart_flush0",  64'(st0), 64'(2'b10));
         if (e == 5) check("restart_flush0b", 64'(st0), 64'(2'b10));
         if (e == 6) check("restart_active0", 64'(st0), 64'(2'b11));
      end

      // Asynchronous reset mid-ACTIVE, then identical power-up timing
      k = 0;
      while (!(st0 == 2'b11 && st1 == 2'b11) && k < 40) begin
         tick();
         k++;
      end
      check("both_active", 64'({st0, st1}), 64'(4'b1111));
      a = 8'h3C;
      repeat (5) tick();
      check("pre_rst_y0", 64'(y0), 64'(8'h3C));
      check("pre_rst_y1", 64'(y1), 64'(8'h3C));
      a = 8'hA5;
      do_reset();
      powerup_seq("rpu");

      // Randomized traffic with power drops, isolation requests, glitches and resets
      for (int c = 0; c < 3000; c++) begin
         a = 8'($urandom);
         if (pwr) begin
            if ($urandom_range(0, 59) == 0) pwr = 1'b0;
         end else if ($urandom_range(0, 5) == 0) begin
            pwr = 1'b1;
         end
         iso = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
         end else if (pwr && $urandom_range(0, 29) == 0) begin
            pwr = 1'b0;
            #2;
            pwr = 1'b1;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
